// File: rtl/gray_img_host.sv
// gray_img_host: host-side partner of the LBP engine.
// Holds a 128x128 gray image, serves the engine's pixel reads, captures the
// engine's LBP result writes into a result RAM and keeps a write count,
// a checksum and sticky done / protocol-error flags.
`timescale 1ns/1ps
module gray_img_host #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              img_we,
  input  logic [ADDR_W-1:0] img_addr,
  input  logic [DATA_W-1:0] img_wdata,
  input  logic              start,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic              gray_ready,
  output logic [DATA_W-1:0] gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   wr_count,
  output logic [21:0]       sum,
  output logic              done,
  output logic              proto_err
);

  localparam int SUM_W = 22;
  // The count saturates at DEPTH, which needs one bit more than an address.
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rd_data_q;

  logic [DATA_W-1:0]   image_mem  [DEPTH];
  logic [DATA_W-1:0]   result_mem [DEPTH];

  // Image RAM: written only while loading; read combinationally by the engine.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && img_we) begin
      image_mem[img_addr] <= img_wdata;
    end
  end

  // Result RAM: written only while serving (includes the finish cycle).
  always_ff @(posedge clk) begin
    if (state_q == ST_SERVE && lbp_valid) begin
      result_mem[lbp_addr] <= lbp_data;
    end
  end

  // Next-state, bookkeeping and protocol checks. A violating action is simply
  // dropped; when a restart and a violation coincide the error flag wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      ST_LOAD: begin
        if (start) state_d = ST_SERVE;
        if (gray_req || lbp_valid) err_d = 1'b1;
      end
      ST_SERVE: begin
        if (lbp_valid) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          sum_d = sum_q + {{(SUM_W-DATA_W){1'b0}}, lbp_data};
        end
        if (finish) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
        if (start || img_we) err_d = 1'b1;
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_SERVE;
          cnt_d   = '0;
          sum_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
        if (gray_req || lbp_valid || img_we) err_d = 1'b1;
      end
      default: state_d = ST_LOAD;
    endcase
    ready_d = (state_d == ST_SERVE);
  end

  // State and status registers, plus the registered result readback port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_LOAD;
      ready_q   <= 1'b0;
      cnt_q     <= '0;
      sum_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_data_q <= result_mem[rd_addr];
    end
  end

  // Pixel data is only driven while serving an active request.
  assign gray_data  = (state_q == ST_SERVE && gray_req) ? image_mem[gray_addr] : '0;
  assign gray_ready = ready_q;
  assign rd_data    = rd_data_q;
  assign wr_count   = cnt_q;
  assign sum        = sum_q;
  assign done       = done_q;
  assign proto_err  = err_q;

endmodule

// File: tb/tb_gray_img_host.sv
// Directed bench for gray_img_host: inputs change on the falling edge,
// outputs are sampled on the falling edge or 1 ns after a drive.
`timescale 1ns/1ps
module tb_gray_img_host;

  logic        clk = 1'b0;
  logic        reset;
  logic        img_we;
  logic [13:0] img_addr;
  logic [7:0]  img_wdata;
  logic        start;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic        gray_ready;
  logic [7:0]  gray_data;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic [13:0] rd_addr;
  logic [7:0]  rd_data;
  logic [14:0] wr_count;
  logic [21:0] sum;
  logic        done;
  logic        proto_err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  gray_img_host dut (
    .clk       (clk),
    .reset     (reset),
    .img_we    (img_we),
    .img_addr  (img_addr),
    .img_wdata (img_wdata),
    .start     (start),
    .gray_req  (gray_req),
    .gray_addr (gray_addr),
    .gray_ready(gray_ready),
    .gray_data (gray_data),
    .lbp_valid (lbp_valid),
    .lbp_addr  (lbp_addr),
    .lbp_data  (lbp_data),
    .finish    (finish),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_count  (wr_count),
    .sum       (sum),
    .done      (done),
    .proto_err (proto_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; img_we = 0; img_addr = '0; img_wdata = '0; start = 0;
    gray_req = 0; gray_addr = '0; lbp_valid = 0; lbp_addr = '0; lbp_data = '0;
    finish = 0; rd_addr = '0;
    tick(); tick();
    check_eq("rst_ready", gray_ready, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_wr_count", wr_count, 0);
    check_eq("rst_sum", sum, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", proto_err, 0);
    reset = 1'b0;

    // 1: load image[i] = i[7:0]; start rides on the last pixel write
    for (int i = 0; i < 16384; i++) begin
      tick();
      img_we = 1; img_addr = 14'(i); img_wdata = i[7:0];
      start = (i == 16383);
    end
    #1 check_eq("ready_in_start_cycle", gray_ready, 0);
    tick();
    img_we = 0; start = 0;
    check_eq("ready_after_start", gray_ready, 1);
    gray_req = 1; gray_addr = 14'h1234;
    #1 check_eq("gray_1234", gray_data, 8'h34);
    gray_addr = 14'h3FFF;
    #1 check_eq("gray_last_px", gray_data, 8'hFF);

    // 2: no request -> zero; single result write and readback
    gray_req = 0;
    #1 check_eq("gray_noreq", gray_data, 0);
    lbp_valid = 1; lbp_addr = 14'd5; lbp_data = 8'hA7;
    tick();
    lbp_valid = 0; rd_addr = 14'd5;
    check_eq("wr_count_1", wr_count, 1);
    check_eq("sum_a7", sum, 22'hA7);
    tick();
    check_eq("rd_5", rd_data, 8'hA7);

    // finish -> DONE; writes ignored, reads flagged
    finish = 1;
    tick();
    finish = 0;
    check_eq("done_set", done, 1);
    check_eq("ready_done", gray_ready, 0);
    lbp_valid = 1; lbp_addr = 14'd9; lbp_data = 8'h33;
    tick();
    lbp_valid = 0;
    check_eq("done_no_count", wr_count, 1);
    check_eq("done_err", proto_err, 1);
    gray_req = 1; gray_addr = 14'h1234;
    #1 check_eq("gray_in_done", gray_data, 0);
    gray_req = 0;
    start = 1;
    tick();
    start = 0;
    check_eq("restart_err", proto_err, 0);
    check_eq("restart_cnt", wr_count, 0);
    check_eq("restart_sum", sum, 0);
    check_eq("restart_done", done, 0);
    check_eq("restart_ready", gray_ready, 1);
    gray_req = 1; gray_addr = 14'h0ABC;
    #1 check_eq("image_kept", gray_data, 8'hBC);
    gray_req = 0;

    // 3: fill every result with 0xFF, then one extra write
    for (int i = 0; i < 16384; i++) begin
      lbp_valid = 1; lbp_addr = 14'(i); lbp_data = 8'hFF;
      tick();
    end
    lbp_valid = 0;
    check_eq("full_cnt", wr_count, 16384);
    check_eq("full_sum", sum, 4177920);
    lbp_valid = 1; lbp_addr = 14'd0; lbp_data = 8'hFF;
    tick();
    lbp_valid = 0;
    check_eq("sat_cnt", wr_count, 16384);
    check_eq("sat_sum", sum, 4178175);

    // 4: write together with finish is captured
    lbp_valid = 1; lbp_addr = 14'd7; lbp_data = 8'h11; finish = 1;
    tick();
    lbp_valid = 0; finish = 0; rd_addr = 14'd7;
    check_eq("fin_done", done, 1);
    check_eq("fin_ready", gray_ready, 0);
    check_eq("fin_sum", sum, 4178192);
    tick();
    check_eq("fin_rd_7", rd_data, 8'h11);
    lbp_valid = 1; lbp_addr = 14'd8; lbp_data = 8'h22;
    tick();
    lbp_valid = 0; rd_addr = 14'd8;
    check_eq("late_sum", sum, 4178192);
    check_eq("late_err", proto_err, 1);
    tick();
    check_eq("late_rd_8", rd_data, 8'hFF);

    // 5: restart, then start while serving is an error and keeps SERVE
    start = 1;
    tick();
    start = 0;
    check_eq("r2_err", proto_err, 0);
    check_eq("r2_cnt", wr_count, 0);
    lbp_valid = 1; lbp_addr = 14'd3; lbp_data = 8'h40;
    tick();
    lbp_valid = 0;
    check_eq("r2_cnt1", wr_count, 1);
    start = 1;
    tick();
    start = 0;
    check_eq("start_in_serve_err", proto_err, 1);
    check_eq("start_in_serve_ready", gray_ready, 1);

    // 6: asynchronous reset mid-SERVE, then LOAD behaviour again
    reset = 1;
    #1;
    check_eq("arst_ready", gray_ready, 0);
    check_eq("arst_cnt", wr_count, 0);
    check_eq("arst_sum", sum, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_err", proto_err, 0);
    tick();
    reset = 0;
    check_eq("arst_rd", rd_data, 0);
    gray_req = 1; gray_addr = 14'h1234;
    #1 check_eq("gray_in_load", gray_data, 0);
    tick();
    gray_req = 0;
    check_eq("load_req_err", proto_err, 1);
    img_we = 1; img_addr = 14'h1234; img_wdata = 8'h5A; start = 1;
    tick();
    img_we = 0; start = 0;
    gray_req = 1; gray_addr = 14'h1234;
    #1 check_eq("reload_px", gray_data, 8'h5A);
    gray_addr = 14'h1235;
    #1 check_eq("neighbour_px", gray_data, 8'h35);
    gray_req = 0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
